// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a clock divider monitor and its environment:
// enable/ratio/divided-clock inputs and the measured period, high time
// and health status outputs.
interface clk_div_monitor_if #(
  parameter int WIDTH = 4
);
  logic             i_mon_en;
  logic [WIDTH-1:0] i_div_ratio;
  logic             i_div_clk;
  logic [WIDTH-1:0] o_period;
  logic [WIDTH-1:0] o_high_time;
  logic             o_locked;
  logic             o_err;
  logic             o_timeout;

  // Environment side: drives configuration and the clock under test
  modport master (
    output i_mon_en, i_div_ratio, i_div_clk,
    input  o_period, o_high_time, o_locked, o_err, o_timeout
  );

  // Monitor side
  modport slave (
    input  i_mon_en, i_div_ratio, i_div_clk,
    output o_period, o_high_time, o_locked, o_err, o_timeout
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Clock divider health monitor. Samples the divided clock in the reference
// domain, measures its period and high time in reference cycles, and reports
// lock after LOCK_CNT consecutive good periods, a one-cycle error pulse on a
// bad period, and a timeout level when no rising edge arrives in time.
module clk_div_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  clk_div_monitor_if.slave bus
);
  localparam int CW = WIDTH + 1;  // cycle counter width
  localparam int PW = WIDTH + 2;  // counter+1 without wrap

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_MEASURE, ST_LOCKED} state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_sync;
  logic             r_hist;
  logic [WIDTH-1:0] r_ratio;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [3:0]       r_match, w_match_next;
  logic             r_high_ok, w_high_ok_next;
  logic [WIDTH-1:0] r_period, w_period_next;
  logic [WIDTH-1:0] r_high, w_high_next;
  logic             r_locked, w_locked_next;
  logic             r_err, w_err_next;
  logic             r_timeout, w_timeout_next;

  logic             w_rise, w_fall, w_idle_req, w_ratio_chg, w_cnt_sat;
  logic             w_period_ok, w_high_match;
  logic [PW-1:0]    w_cnt_p1;

  assign w_rise       = r_sync[1] & ~r_hist;
  assign w_fall       = ~r_sync[1] & r_hist;
  assign w_idle_req   = ~bus.i_mon_en | (bus.i_div_ratio < WIDTH'(2));
  assign w_ratio_chg  = (bus.i_div_ratio != r_ratio);
  assign w_cnt_sat    = &r_cnt;
  // Measured length is the counter value plus the edge cycle itself
  assign w_cnt_p1     = {1'b0, r_cnt} + PW'(1);
  assign w_period_ok  = (w_cnt_p1 == PW'(r_ratio));
  assign w_high_match = (w_cnt_p1 == PW'(r_ratio >> 1));

  assign bus.o_period    = r_period;
  assign bus.o_high_time = r_high;
  assign bus.o_locked    = r_locked;
  assign bus.o_err       = r_err;
  assign bus.o_timeout   = r_timeout;

  // Two-flop synchroniser, edge history flop and registered ratio
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_ratio <= '0;
    end else begin
      r_sync  <= {r_sync[0], bus.i_div_clk};
      r_hist  <= r_sync[1];
      r_ratio <= bus.i_div_ratio;
    end
  end

  // Next-state, counter and capture logic
  always_comb begin
    w_state_next   = r_state;
    w_match_next   = r_match;
    w_high_ok_next = r_high_ok;
    w_period_next  = r_period;
    w_high_next    = r_high;
    w_locked_next  = r_locked;
    w_err_next     = 1'b0;
    w_timeout_next = r_timeout;
    if (w_rise)
      w_cnt_next = '0;
    else if (!w_cnt_sat)
      w_cnt_next = r_cnt + CW'(1);
    else
      w_cnt_next = r_cnt;

    if (w_idle_req) begin
      // Disable or unusable ratio wins over any edge in the same cycle
      w_state_next   = ST_IDLE;
      w_cnt_next     = '0;
      w_match_next   = '0;
      w_high_ok_next = 1'b0;
      w_period_next  = '0;
      w_high_next    = '0;
      w_locked_next  = 1'b0;
      w_timeout_next = 1'b0;
    end else begin
      if (w_rise)
        w_timeout_next = 1'b0;
      if (r_state == ST_IDLE) begin
        w_state_next = ST_ACQUIRE;
      end else if (w_ratio_chg) begin
        // New ratio: restart acquisition silently
        w_state_next  = ST_ACQUIRE;
        w_locked_next = 1'b0;
        w_match_next  = '0;
      end else begin
        case (r_state)
          ST_ACQUIRE: begin
            if (w_rise)
              w_state_next = ST_MEASURE;
          end
          ST_MEASURE, ST_LOCKED: begin
            if (w_rise) begin
              w_period_next = w_cnt_p1[WIDTH-1:0];
              if (w_period_ok && r_high_ok) begin
                if (r_state == ST_MEASURE) begin
                  if (r_match == 4'(LOCK_CNT - 1)) begin
                    w_match_next  = 4'(LOCK_CNT);
                    w_state_next  = ST_LOCKED;
                    w_locked_next = 1'b1;
                  end else begin
                    w_match_next = r_match + 4'd1;
                  end
                end
              end else begin
                w_err_next    = 1'b1;
                w_match_next  = '0;
                w_locked_next = 1'b0;
                w_state_next  = ST_MEASURE;
              end
            end else if (w_fall) begin
              w_high_next    = w_cnt_p1[WIDTH-1:0];
              w_high_ok_next = w_high_match;
            end else if (w_cnt_sat) begin
              // No rising edge within the counter range: clock lost
              w_timeout_next = 1'b1;
              w_locked_next  = 1'b0;
              w_match_next   = '0;
              w_state_next   = ST_ACQUIRE;
            end
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_match   <= '0;
      r_high_ok <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_match   <= w_match_next;
      r_high_ok <= w_high_ok_next;
      r_period  <= w_period_next;
      r_high    <= w_high_next;
      r_locked  <= w_locked_next;
      r_err     <= w_err_next;
      r_timeout <= w_timeout_next;
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: a divider waveform generator drives the
// monitor; an edge-timestamp reference model predicts every change of the
// output vector and the cycle it occurs in, and a monitor process compares.
module tb_clk_div_monitor;
  localparam int W    = 4;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  clk_div_monitor_if #(.WIDTH(W)) bus ();

  clk_div_monitor #(.WIDTH(W), .LOCK_CNT(LOCK)) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [10:0] vec; int cyc; } exp_t;
  exp_t exp_q[$];

  // Current programmed configuration used by the divider generator
  logic       cur_en;
  logic [3:0] cur_ratio;

  // Reference model state: timestamps of edges as seen by the monitor
  int          m_mode;       // 0 off, 1 waiting for first rise, 2 measuring
  int          m_last_rise;
  int          m_run;
  bit          m_high_ok, m_locked, m_timeout, m_err;
  int          m_period, m_high;
  logic [3:0]  m_rprev;
  logic        m_d[4];       // divided clock driven 1..4 cycles before the edge
  logic [10:0] m_prev_vec;

  function automatic logic [10:0] dut_vec();
    return {bus.o_period, bus.o_high_time, bus.o_locked, bus.o_err, bus.o_timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_last_rise = 0; m_run = 0;
    m_high_ok = 0; m_locked = 0; m_timeout = 0; m_err = 0;
    m_period = 0; m_high = 0; m_rprev = '0; m_prev_vec = '0;
    for (int i = 0; i < 4; i++) m_d[i] = 1'b0;
  endfunction

  // Predict the outputs after the coming clock edge
  function automatic void model_edge(input logic en, input logic [3:0] ratio, input logic d);
    int e, el, cap;
    logic rise, fall;
    logic [10:0] v;
    e = cyc + 1;
    m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = d;
    // Input edges reach the monitor three edges after being driven
    rise = m_d[2] && !m_d[3];
    fall = !m_d[2] && m_d[3];
    m_err = 0;
    if (!en || ratio < 2) begin
      m_mode = 0; m_locked = 0; m_timeout = 0; m_run = 0;
      m_period = 0; m_high = 0; m_high_ok = 0;
    end else begin
      if (rise) m_timeout = 0;
      if (m_mode == 0) m_mode = 1;
      else if (ratio != m_rprev) begin
        m_mode = 1; m_locked = 0; m_run = 0;
      end else if (m_mode == 1) begin
        if (rise) begin m_mode = 2; m_last_rise = e; end
      end else begin
        el  = e - m_last_rise;
        cap = (el > 32) ? 32 : el;
        if (rise) begin
          m_period = cap % 16;
          if (cap == int'(ratio) && m_high_ok) begin
            if (m_run < LOCK) m_run++;
            if (m_run == LOCK) m_locked = 1;
          end else begin
            m_err = 1; m_run = 0; m_locked = 0;
          end
          m_last_rise = e;
        end else if (fall) begin
          m_high    = cap % 16;
          m_high_ok = (cap == int'(ratio) / 2);
        end else if (el >= 32) begin
          m_timeout = 1; m_locked = 0; m_run = 0; m_mode = 1;
        end
      end
    end
    m_rprev = ratio;
    v = {4'(m_period), 4'(m_high), m_locked, m_err, m_timeout};
    if (v != m_prev_vec) exp_q.push_back('{v, e});
    m_prev_vec = v;
  endfunction

  task automatic step(input logic en, input logic [3:0] ratio, input logic d);
    bus.i_mon_en    = en;
    bus.i_div_ratio = ratio;
    bus.i_div_clk   = d;
    model_edge(en, ratio, d);
    @(posedge clk);
    #1;
  endtask

  task automatic periods(input int len, input int hi, input int count);
    for (int p = 0; p < count; p++)
      for (int k = 0; k < len; k++)
        step(cur_en, cur_ratio, (k < hi));
  endtask

  task automatic hold(input int len, input logic d);
    for (int k = 0; k < len; k++) step(cur_en, cur_ratio, d);
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_vec()), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Scoreboard monitor: every output change must match the next prediction
  initial begin
    logic [10:0] prev, cur;
    exp_t ex;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_vec();
      if (!rst_n) prev = cur;
      else if (cur != prev) begin
        prev = cur;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected cyc=%0d got=%h exp=no_change", cyc, cur);
        end else begin
          ex = exp_q.pop_front();
          if (ex.vec !== cur || ex.cyc != cyc) begin
            failures++;
            $display("FAIL sb_out cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur, ex.vec, ex.cyc);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    cur_en = 1'b0; cur_ratio = '0;
    bus.i_mon_en = 1'b0; bus.i_div_ratio = '0; bus.i_div_clk = 1'b0;
    #1 check("reset_outputs", 32'(dut_vec()), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // N=4, 5, 2: lock with expected period and high time
    cur_en = 1'b1; cur_ratio = 4; periods(4, 2, 8);
    check("n4_locked", 32'(bus.o_locked), 1);
    check("n4_period", 32'(bus.o_period), 4);
    check("n4_high", 32'(bus.o_high_time), 2);
    cur_ratio = 5; periods(5, 2, 8);
    check("n5_locked", 32'(bus.o_locked), 1);
    check("n5_period", 32'(bus.o_period), 5);
    check("n5_high", 32'(bus.o_high_time), 2);
    cur_ratio = 2; periods(2, 1, 8);
    check("n2_locked", 32'(bus.o_locked), 1);
    check("n2_period", 32'(bus.o_period), 2);
    check("n2_high", 32'(bus.o_high_time), 1);

    // N=6 locked, one stretched period, then relock
    cur_ratio = 6; periods(6, 3, 8);
    check("n6_locked", 32'(bus.o_locked), 1);
    periods(7, 3, 1);
    periods(6, 3, 1);
    check("stretch_unlocked", 32'(bus.o_locked), 0);
    check("stretch_period", 32'(bus.o_period), 7);
    periods(6, 3, 4);
    check("stretch_relocked", 32'(bus.o_locked), 1);

    // Loss of clock
    cur_ratio = 4; periods(4, 2, 8);
    hold(40, 1'b0);
    check("timeout_set", 32'(bus.o_timeout), 1);
    check("timeout_unlocked", 32'(bus.o_locked), 0);
    periods(4, 2, 1);
    check("timeout_cleared", 32'(bus.o_timeout), 0);
    periods(4, 2, 6);
    check("timeout_relocked", 32'(bus.o_locked), 1);

    // Ratio change while locked
    cur_ratio = 8; periods(8, 4, 8);
    check("n8_locked", 32'(bus.o_locked), 1);
    check("n8_period", 32'(bus.o_period), 8);
    check("n8_high", 32'(bus.o_high_time), 4);

    // Ratio below 2 and disable force idle
    cur_ratio = 1; hold(5, 1'b0);
    check("ratio1_idle", 32'(dut_vec()), 0);
    cur_ratio = 4; periods(4, 2, 8);
    cur_en = 1'b0; hold(3, 1'b0);
    check("disable_idle", 32'(dut_vec()), 0);
    cur_en = 1'b1;

    // Asynchronous reset while measuring
    periods(4, 2, 3);
    check("measure_period", 32'(bus.o_period), 4);
    async_reset();

    // Randomised segments with glitches, drops and stalls
    for (int s = 0; s < 40; s++) begin
      int n, np, r;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 15));
      cur_ratio = 4'(n);
      if (n < 2) begin
        hold(4, 1'b0);
        continue;
      end
      np = $urandom_range(2, 8);
      for (int p = 0; p < np; p++) begin
        r = $urandom_range(0, 19);
        if (r == 0) periods(n + 1, n / 2, 1);
        else if (r == 1) periods(n, $urandom_range(1, n - 1), 1);
        else if (r == 2) begin
          cur_en = 1'b0; hold($urandom_range(1, 3), 1'b0); cur_en = 1'b1;
        end
        else if (r == 3) hold($urandom_range(28, 36), 1'b0);
        else periods(n, n / 2, 1);
      end
    end

    cur_en = 1'b0;
    hold(6, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Reference-domain checker for the configurable clock divider output. It samples the divided clock with i_ref_clk and measures its period and high time in reference cycles. It compares both against the programmed ratio and reports lock, mismatch and loss-of-clock. It sits beside each divider instance and feeds the system controller's clock-health status.

Parameters:
WIDTH, 4, width of i_div_ratio and of o_period / o_high_time
LOCK_CNT, 4, consecutive matching periods required to assert o_locked (range 1..15)

Ports:
i_ref_clk  input  1  reference clock; the same clock that drives the divider
i_rst_n  input  1  asynchronous active-low reset
i_mon_en  input  1  monitor enable; low forces IDLE
i_div_ratio  input  WIDTH  programmed divide ratio N
i_div_clk  input  1  divided clock under test, sampled as data
o_period  output  WIDTH  last measured period, in ref cycles
o_high_time  output  WIDTH  last measured high time, in ref cycles
o_locked  output  1  LOCK_CNT consecutive good periods seen
o_err  output  1  one-cycle pulse on period or high-time mismatch
o_timeout  output  1  level; no rising edge within timeout window

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; counters 0; synchroniser flops 0; state IDLE.
- Input path: 2-flop synchroniser, then one history flop. Rise/fall detect is comb from sync[1] vs hist. An edge is detected 2 cycles after i_div_clk changes; measured values are unaffected by this latency.
- Expected values: period = N; high time = floor(N/2).
- Cycle counter cnt, width WIDTH+1:
  - cleared on each detected rise;
  - otherwise increments, saturating at all-ones.
- States:
  - IDLE: entered while i_mon_en=0 or i_div_ratio<2. Clears o_locked, o_timeout, match count, cnt; holds o_period/o_high_time at 0. Leaves to ACQUIRE when enabled with N>=2.
  - ACQUIRE: waits for first rise; falls ignored. On rise: cnt cleared, go MEASURE, nothing captured.
  - MEASURE: on fall, o_high_time <= cnt+1 (truncated to WIDTH); high check recorded. On rise, o_period <= cnt+1 (truncated to WIDTH); period check evaluated.
    - Good period: period==N and last high time==floor(N/2). Increments match count; at LOCK_CNT go LOCKED and set o_locked the same cycle as the capture.
    - Bad period: o_err=1 for one cycle; match count cleared.
  - LOCKED: same captures. A bad period pulses o_err, clears o_locked and match count, and returns to MEASURE.
- Timeout: in MEASURE/LOCKED, if cnt reaches 2^(WIDTH+1)-1:
  - o_timeout=1, o_locked=0, match count cleared, go ACQUIRE;
  - o_timeout stays high until the next detected rise.
- Ratio change: i_div_ratio is registered. Any change while not IDLE drops o_locked next cycle, clears match count and goes ACQUIRE; no o_err for the change.
- Simultaneous events: a rise in the same cycle as timeout saturation is treated as an edge (capture, no timeout). A disable/ratio<2 in the same cycle as an edge goes to IDLE with no capture.
- i_mon_en low mid-operation: IDLE next cycle, status cleared; re-enable restarts from ACQUIRE.

Test Plan:
- N=4 divider running, i_mon_en=1 -> o_period=4, o_high_time=2; o_locked rises on 4th captured period after first edge; o_err never pulses.
- N=5 -> o_period=5, o_high_time=2, locks after 4 periods; N=2 -> period 2, high 1, locks.
- Locked at N=6, then stretch one period to 7 cycles (high 3) -> single-cycle o_err at that rise, o_locked=0, re-locks 4 good periods later.
- Locked at N=4, hold i_div_clk low -> o_timeout=1 and o_locked=0 when cnt hits 31 (WIDTH=4); first rise clears o_timeout, state ACQUIRE->MEASURE.
- Locked at N=4, change i_div_ratio to 8 while divider follows -> o_locked drops next cycle without o_err; re-locks at period 8, high 4.
- i_div_ratio=1, or i_mon_en=0 mid-lock -> IDLE, all outputs 0. Assert i_rst_n=0 mid-MEASURE -> outputs 0 immediately, asynchronous to the clock.
